axis_pipeline_reg: RTL and testbench

AXIS_PIPELINE_REG -- requirements
Module: axis_pipeline_reg

---
 rtl/axis_pkg.sv | 69 ++++++
 rtl/ifc_axis.sv | 36 +++
 rtl/axis_reg_stage.sv | 113 +++++++++++
 rtl/axis_pipeline_reg.sv | 153 +++++++++++++++
 tb/tb_axis_pipeline_reg.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// ----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream pipeline register:
//   - axis_reg_type_e : stage implementation selector (bypass / simple / skid)
//   - axis_*_offset   : bit offsets of each sideband field inside the packed
//                       per-stage word (DATA at bit 0, then KEEP, LAST, ID,
//                       DEST, USER; a field only takes space when enabled)
//   - axis_word_width : total width of the packed word
// ----------------------------------------------------------------------------
package axis_pkg;

    typedef enum int unsigned {
        AXIS_REG_BYPASS = 0,
        AXIS_REG_SIMPLE = 1,
        AXIS_REG_SKID   = 2
    } axis_reg_type_e;

    function automatic int unsigned axis_keep_offset(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned axis_last_offset(
        input int unsigned data_w,
        input int unsigned keep_en, input int unsigned keep_w
    );
        return axis_keep_offset(data_w) + ((keep_en != 0) ? keep_w : 32'd0);
    endfunction

    function automatic int unsigned axis_id_offset(
        input int unsigned data_w,
        input int unsigned keep_en, input int unsigned keep_w,
        input int unsigned last_en
    );
        return axis_last_offset(data_w, keep_en, keep_w) + ((last_en != 0) ? 32'd1 : 32'd0);
    endfunction

    function automatic int unsigned axis_dest_offset(
        input int unsigned data_w,
        input int unsigned keep_en, input int unsigned keep_w,
        input int unsigned last_en,
        input int unsigned id_en,   input int unsigned id_w
    );
        return axis_id_offset(data_w, keep_en, keep_w, last_en) + ((id_en != 0) ? id_w : 32'd0);
    endfunction

    function automatic int unsigned axis_user_offset(
        input int unsigned data_w,
        input int unsigned keep_en, input int unsigned keep_w,
        input int unsigned last_en,
        input int unsigned id_en,   input int unsigned id_w,
        input int unsigned dest_en, input int unsigned dest_w
    );
        return axis_dest_offset(data_w, keep_en, keep_w, last_en, id_en, id_w)
               + ((dest_en != 0) ? dest_w : 32'd0);
    endfunction

    function automatic int unsigned axis_word_width(
        input int unsigned data_w,
        input int unsigned keep_en, input int unsigned keep_w,
        input int unsigned last_en,
        input int unsigned id_en,   input int unsigned id_w,
        input int unsigned dest_en, input int unsigned dest_w,
        input int unsigned user_en, input int unsigned user_w
    );
        return axis_user_offset(data_w, keep_en, keep_w, last_en, id_en, id_w, dest_en, dest_w)
               + ((user_en != 0) ? user_w : 32'd0);
    endfunction

endpackage

// File: rtl/ifc_axis.sv
// ----------------------------------------------------------------------------
// ifc_axis
// AXI-Stream bundle carrying its own clock and reset.
//   clk, rst : interface ports, shared by both ends
//   tdata, tvalid, tready, tlast, tkeep, tid, tdest, tuser : stream fields
// Modports: slave (receives a stream), master (drives a stream).
// ----------------------------------------------------------------------------
interface ifc_axis #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 1
) (
    input logic clk,
    input logic rst
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;

    modport slave (
        input  clk, rst, tdata, tvalid, tlast, tkeep, tid, tdest, tuser,
        output tready
    );

    modport master (
        input  clk, rst, tready,
        output tdata, tvalid, tlast, tkeep, tid, tdest, tuser
    );
endinterface

// File: rtl/axis_reg_stage.sv
// ----------------------------------------------------------------------------
// axis_reg_stage
// One pipeline stage operating on a packed word.
//   REG_TYPE = AXIS_REG_SIMPLE : single register, ready = m_ready | !valid
//   REG_TYPE = AXIS_REG_SKID   : primary + expansion register, ready is
//                                !exp_valid (no combinational ready path)
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   s_data_i/s_valid_i/s_ready_o  upstream handshake
//   m_data_o/m_valid_o/m_ready_i  downstream handshake
//   occ_o                   beats held (only with AXIS_PIPELINE_REG_STATS_EN)
// Valid flags are reset; data registers are not.
// ----------------------------------------------------------------------------
module axis_reg_stage
    import axis_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int REG_TYPE = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
`ifdef AXIS_PIPELINE_REG_STATS_EN
    ,
    output logic [1:0]       occ_o
`endif
);

    if (REG_TYPE == int'(AXIS_REG_SIMPLE)) begin : g_simple
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q, data_d;

        assign s_ready_o = m_ready_i | ~valid_q;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (s_ready_o) begin
                valid_d = s_valid_i;
                data_d  = s_data_i;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) valid_q <= 1'b0;
            else       valid_q <= valid_d;
        end

        always_ff @(posedge clk_i) begin
            data_q <= data_d;
        end

        assign m_data_o  = data_q;
        assign m_valid_o = valid_q;
`ifdef AXIS_PIPELINE_REG_STATS_EN
        assign occ_o = {1'b0, valid_q};
`endif
    end else begin : g_skid
        logic             prim_valid_q, prim_valid_d;
        logic             exp_valid_q, exp_valid_d;
        logic [WIDTH-1:0] prim_q, prim_d;
        logic [WIDTH-1:0] exp_q, exp_d;

        assign s_ready_o = ~exp_valid_q;

        // Expansion always holds the older beat, so it is emitted first.
        always_comb begin
            prim_valid_d = prim_valid_q;
            prim_d       = prim_q;
            exp_valid_d  = exp_valid_q;
            exp_d        = exp_q;
            if (exp_valid_q) begin
                if (m_ready_i) exp_valid_d = 1'b0;
            end else if (prim_valid_q && !m_ready_i) begin
                if (s_valid_i) begin
                    exp_valid_d = 1'b1;
                    exp_d       = prim_q;
                    prim_d      = s_data_i;
                end
            end else begin
                prim_valid_d = s_valid_i;
                prim_d       = s_data_i;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                prim_valid_q <= 1'b0;
                exp_valid_q  <= 1'b0;
            end else begin
                prim_valid_q <= prim_valid_d;
                exp_valid_q  <= exp_valid_d;
            end
        end

        always_ff @(posedge clk_i) begin
            prim_q <= prim_d;
            exp_q  <= exp_d;
        end

        assign m_valid_o = exp_valid_q | prim_valid_q;
        assign m_data_o  = exp_valid_q ? exp_q : prim_q;
`ifdef AXIS_PIPELINE_REG_STATS_EN
        assign occ_o = {1'b0, prim_valid_q} + {1'b0, exp_valid_q};
`endif
    end

endmodule

// File: rtl/axis_pipeline_reg.sv
// ----------------------------------------------------------------------------
// axis_pipeline_reg
// AXI-Stream pipeline register: LENGTH cascaded axis_reg_stage instances
// (REG_TYPE 1 = simple, 2 = skid) or a combinational bypass (REG_TYPE 0).
// Ports:
//   s_axis_ifc      upstream stream (clk/rst of the block are taken from it)
//   m_axis_ifc      downstream stream
//   stat_occupancy  beats currently held        (AXIS_PIPELINE_REG_STATS_EN)
//   stat_stall_cnt  saturating count of cycles with m_tvalid & !m_tready
//                                                (AXIS_PIPELINE_REG_STATS_EN)
// Disabled output fields are constant: tkeep all-ones, others zero.
// ----------------------------------------------------------------------------
module axis_pipeline_reg
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE = 0,
    parameter int ID_ENABLE   = 0,
    parameter int DEST_ENABLE = 0,
    parameter int USER_ENABLE = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int REG_TYPE    = 2,
    parameter int LENGTH      = 2
) (
    ifc_axis.slave  s_axis_ifc,
    ifc_axis.master m_axis_ifc
`ifdef AXIS_PIPELINE_REG_STATS_EN
    ,
    output logic [$clog2(2*LENGTH+1)-1:0] stat_occupancy,
    output logic [31:0]                   stat_stall_cnt
`endif
);

    localparam int unsigned KEEP_OFF = axis_keep_offset(DATA_WIDTH);
    localparam int unsigned LAST_OFF = axis_last_offset(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH);
    localparam int unsigned ID_OFF   = axis_id_offset(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
                                                      LAST_ENABLE);
    localparam int unsigned DEST_OFF = axis_dest_offset(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
                                                        LAST_ENABLE, ID_ENABLE, ID_WIDTH);
    localparam int unsigned USER_OFF = axis_user_offset(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
                                                        LAST_ENABLE, ID_ENABLE, ID_WIDTH,
                                                        DEST_ENABLE, DEST_WIDTH);
    localparam int unsigned WORD_W   = axis_word_width(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
                                                       LAST_ENABLE, ID_ENABLE, ID_WIDTH,
                                                       DEST_ENABLE, DEST_WIDTH,
                                                       USER_ENABLE, USER_WIDTH);

    logic clk;
    logic rst;
    assign clk = s_axis_ifc.clk;
    assign rst = s_axis_ifc.rst;

    logic [WORD_W-1:0] s_word;
    logic [WORD_W-1:0] m_word;

    // Fields are packed with shifts rather than part-selects so that the
    // offsets of disabled fields never produce out-of-range selects.
    always_comb begin
        s_word = WORD_W'(s_axis_ifc.tdata);
        if (KEEP_ENABLE != 0) s_word = s_word | (WORD_W'(s_axis_ifc.tkeep) << KEEP_OFF);
        if (LAST_ENABLE != 0) s_word = s_word | (WORD_W'(s_axis_ifc.tlast) << LAST_OFF);
        if (ID_ENABLE   != 0) s_word = s_word | (WORD_W'(s_axis_ifc.tid)   << ID_OFF);
        if (DEST_ENABLE != 0) s_word = s_word | (WORD_W'(s_axis_ifc.tdest) << DEST_OFF);
        if (USER_ENABLE != 0) s_word = s_word | (WORD_W'(s_axis_ifc.tuser) << USER_OFF);
    end

    assign m_axis_ifc.tdata = m_word[DATA_WIDTH-1:0];
    assign m_axis_ifc.tkeep = (KEEP_ENABLE != 0) ? KEEP_WIDTH'(m_word >> KEEP_OFF) : '1;
    assign m_axis_ifc.tlast = (LAST_ENABLE != 0) ? 1'(m_word >> LAST_OFF) : 1'b0;
    assign m_axis_ifc.tid   = (ID_ENABLE   != 0) ? ID_WIDTH'(m_word >> ID_OFF) : '0;
    assign m_axis_ifc.tdest = (DEST_ENABLE != 0) ? DEST_WIDTH'(m_word >> DEST_OFF) : '0;
    assign m_axis_ifc.tuser = (USER_ENABLE != 0) ? USER_WIDTH'(m_word >> USER_OFF) : '0;

`ifdef AXIS_PIPELINE_REG_STATS_EN
    localparam int OCC_W = $clog2(2*LENGTH+1);
    logic [OCC_W-1:0] occ_sum;
    logic [31:0]      stall_cnt_q, stall_cnt_d;
`endif

    if (REG_TYPE == int'(AXIS_REG_BYPASS)) begin : g_bypass
        assign m_word            = s_word;
        assign m_axis_ifc.tvalid = s_axis_ifc.tvalid;
        assign s_axis_ifc.tready = m_axis_ifc.tready;
`ifdef AXIS_PIPELINE_REG_STATS_EN
        assign occ_sum = '0;
`endif
    end else begin : g_chain
        logic [WORD_W-1:0] chain_data  [LENGTH+1];
        logic              chain_valid [LENGTH+1];
        logic              chain_ready [LENGTH+1];
`ifdef AXIS_PIPELINE_REG_STATS_EN
        logic [1:0]        stage_occ   [LENGTH];
`endif

        assign chain_data[0]       = s_word;
        assign chain_valid[0]      = s_axis_ifc.tvalid;
        assign s_axis_ifc.tready   = chain_ready[0];
        assign m_word              = chain_data[LENGTH];
        assign m_axis_ifc.tvalid   = chain_valid[LENGTH];
        assign chain_ready[LENGTH] = m_axis_ifc.tready;

        for (genvar i = 0; i < LENGTH; i++) begin : g_stage
            axis_reg_stage #(
                .WIDTH    (WORD_W),
                .REG_TYPE (REG_TYPE)
            ) u_stage (
                .clk_i     (clk),
                .rst_i     (rst),
                .s_data_i  (chain_data[i]),
                .s_valid_i (chain_valid[i]),
                .s_ready_o (chain_ready[i]),
                .m_data_o  (chain_data[i+1]),
                .m_valid_o (chain_valid[i+1]),
                .m_ready_i (chain_ready[i+1])
`ifdef AXIS_PIPELINE_REG_STATS_EN
                ,
                .occ_o     (stage_occ[i])
`endif
            );
        end

`ifdef AXIS_PIPELINE_REG_STATS_EN
        always_comb begin
            occ_sum = '0;
            for (int unsigned i = 0; i < LENGTH; i++) begin
                occ_sum = occ_sum + OCC_W'(stage_occ[i]);
            end
        end
`endif
    end

`ifdef AXIS_PIPELINE_REG_STATS_EN
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_axis_ifc.tvalid && !m_axis_ifc.tready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stat_occupancy = occ_sum;
    assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_axis_pipeline_reg.sv
module tb_axis_pipeline_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // u0: skid, LENGTH 2 | u1: skid, LENGTH 1 | u2: simple, LENGTH 3, all sidebands | u3: bypass
    ifc_axis #(.DATA_WIDTH(8))  s0 (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(8))  m0 (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(8))  s1 (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(8))  m1 (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(16)) s2 (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(16)) m2 (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(8))  s3 (.clk(clk), .rst(rst));
    ifc_axis #(.DATA_WIDTH(8))  m3 (.clk(clk), .rst(rst));

`ifdef AXIS_PIPELINE_REG_STATS_EN
    logic [2:0]  occ0, occ2, occ3;
    logic [1:0]  occ1;
    logic [31:0] stall0, stall1, stall2, stall3;
`endif

    axis_pipeline_reg #(.DATA_WIDTH(8), .REG_TYPE(2), .LENGTH(2)) u0 (
        .s_axis_ifc(s0), .m_axis_ifc(m0)
`ifdef AXIS_PIPELINE_REG_STATS_EN
        , .stat_occupancy(occ0), .stat_stall_cnt(stall0)
`endif
    );
    axis_pipeline_reg #(.DATA_WIDTH(8), .REG_TYPE(2), .LENGTH(1)) u1 (
        .s_axis_ifc(s1), .m_axis_ifc(m1)
`ifdef AXIS_PIPELINE_REG_STATS_EN
        , .stat_occupancy(occ1), .stat_stall_cnt(stall1)
`endif
    );
    axis_pipeline_reg #(.DATA_WIDTH(16), .LAST_ENABLE(1), .ID_ENABLE(1), .DEST_ENABLE(1),
                        .USER_ENABLE(1), .REG_TYPE(1), .LENGTH(3)) u2 (
        .s_axis_ifc(s2), .m_axis_ifc(m2)
`ifdef AXIS_PIPELINE_REG_STATS_EN
        , .stat_occupancy(occ2), .stat_stall_cnt(stall2)
`endif
    );
    axis_pipeline_reg #(.DATA_WIDTH(8), .REG_TYPE(0)) u3 (
        .s_axis_ifc(s3), .m_axis_ifc(m3)
`ifdef AXIS_PIPELINE_REG_STATS_EN
        , .stat_occupancy(occ3), .stat_stall_cnt(stall3)
`endif
    );

    task automatic init_inputs();
        s0.tdata = '0; s0.tvalid = 0; s0.tlast = 0; s0.tkeep = '1; s0.tid = '0; s0.tdest = '0; s0.tuser = '0;
        s1.tdata = '0; s1.tvalid = 0; s1.tlast = 0; s1.tkeep = '1; s1.tid = '0; s1.tdest = '0; s1.tuser = '0;
        s2.tdata = '0; s2.tvalid = 0; s2.tlast = 0; s2.tkeep = '1; s2.tid = '0; s2.tdest = '0; s2.tuser = '0;
        s3.tdata = '0; s3.tvalid = 0; s3.tlast = 0; s3.tkeep = '1; s3.tid = '0; s3.tdest = '0; s3.tuser = '0;
        m0.tready = 0; m1.tready = 0; m2.tready = 0; m3.tready = 0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        tests++; if (m0.tvalid !== 1'b0) begin fails++; $display("FAIL reset_m0_tvalid: got %b expected 0", m0.tvalid); end
        tests++; if (m1.tvalid !== 1'b0) begin fails++; $display("FAIL reset_m1_tvalid: got %b expected 0", m1.tvalid); end
        tests++; if (m2.tvalid !== 1'b0) begin fails++; $display("FAIL reset_m2_tvalid: got %b expected 0", m2.tvalid); end
        tests++; if (s0.tready !== 1'b1) begin fails++; $display("FAIL reset_s0_tready: got %b expected 1", s0.tready); end
        tests++; if (s1.tready !== 1'b1) begin fails++; $display("FAIL reset_s1_tready: got %b expected 1", s1.tready); end
        @(negedge clk); rst = 0;
        @(negedge clk); #1;
        tests++; if (s0.tready !== 1'b1) begin fails++; $display("FAIL post_reset_s0_tready: got %b expected 1", s0.tready); end
        tests++; if (m0.tvalid !== 1'b0) begin fails++; $display("FAIL post_reset_m0_tvalid: got %b expected 0", m0.tvalid); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        int in_stalls = 0;
        m0.tready = 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (sent < 16) begin s0.tvalid = 1; s0.tdata = 8'(sent + 1); end
            else s0.tvalid = 0;
            #1;
            if (s0.tvalid && !s0.tready) in_stalls++;
            if (s0.tvalid && s0.tready) sent++;
            if (m0.tvalid) begin
                tests++;
                if (m0.tdata !== 8'(got + 1) || c != got + 2) begin
                    fails++;
                    $display("FAIL b2b_beat%0d: got data %h at cycle %0d expected %h at cycle %0d",
                             got, m0.tdata, c, 8'(got + 1), got + 2);
                end
                got++;
            end
        end
        s0.tvalid = 0;
        tests++; if (got != 16) begin fails++; $display("FAIL b2b_count: got %0d expected 16", got); end
        tests++; if (in_stalls != 0) begin fails++; $display("FAIL b2b_in_stalls: got %0d expected 0", in_stalls); end
        tests++; if (m0.tlast !== 1'b0 || m0.tid !== 8'h00) begin
            fails++; $display("FAIL b2b_disabled_fields: got last %b id %h expected 0 00", m0.tlast, m0.tid); end
    endtask

    task automatic test_skid_stall();
        logic [7:0] seq [4];
        int sent = 0;
        int got = 0;
        seq[0] = 8'hA5; seq[1] = 8'hA6; seq[2] = 8'hA7; seq[3] = 8'hA8;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            m1.tready = (c >= 6);
            if (sent < 4) begin s1.tvalid = 1; s1.tdata = seq[sent]; end
            else s1.tvalid = 0;
            #1;
            if (c == 1) begin
                tests++; if (s1.tready !== 1'b1) begin fails++; $display("FAIL skid_ready_c1: got %b expected 1", s1.tready); end
            end
            if (c == 2 || c == 5) begin
                tests++; if (s1.tready !== 1'b0) begin fails++; $display("FAIL skid_ready_full_c%0d: got %b expected 0", c, s1.tready); end
                tests++; if (m1.tvalid !== 1'b1 || m1.tdata !== 8'hA5) begin
                    fails++; $display("FAIL skid_hold_c%0d: got %b/%h expected 1/a5", c, m1.tvalid, m1.tdata); end
            end
            if (s1.tvalid && s1.tready) sent++;
            if (m1.tvalid && m1.tready) begin
                tests++;
                if (m1.tdata !== seq[got] || c != got + 6) begin
                    fails++;
                    $display("FAIL skid_out%0d: got %h at cycle %0d expected %h at cycle %0d",
                             got, m1.tdata, c, seq[got], got + 6);
                end
                got++;
            end
        end
        s1.tvalid = 0; m1.tready = 0;
        tests++; if (got != 4) begin fails++; $display("FAIL skid_count: got %0d expected 4", got); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        m3.tready = 0; s3.tdata = 8'h3C; s3.tvalid = 1; s3.tlast = 1; s3.tid = 8'h55;
        #1;
        tests++; if (m3.tdata !== 8'h3C) begin fails++; $display("FAIL bypass_data: got %h expected 3c", m3.tdata); end
        tests++; if (m3.tvalid !== 1'b1) begin fails++; $display("FAIL bypass_valid: got %b expected 1", m3.tvalid); end
        tests++; if (s3.tready !== 1'b0) begin fails++; $display("FAIL bypass_ready0: got %b expected 0", s3.tready); end
        tests++; if (m3.tlast !== 1'b0 || m3.tid !== 8'h00 || m3.tkeep !== 1'b1) begin
            fails++; $display("FAIL bypass_const_fields: got last %b id %h keep %b expected 0 00 1", m3.tlast, m3.tid, m3.tkeep); end
        m3.tready = 1; #1;
        tests++; if (s3.tready !== 1'b1) begin fails++; $display("FAIL bypass_ready1: got %b expected 1", s3.tready); end
        s3.tvalid = 0; #1;
        tests++; if (m3.tvalid !== 1'b0) begin fails++; $display("FAIL bypass_novalid: got %b expected 0", m3.tvalid); end
        s3.tlast = 0; s3.tid = '0; m3.tready = 0;
    endtask

    task automatic test_random_scoreboard();
        logic [35:0] q [$];
        logic [35:0] exp_w;
        logic [35:0] act_w;
        int acc = 0;
        int outn = 0;
        bit pending = 0;
        for (int c = 0; c < 12000 && outn < 1000; c++) begin
            @(negedge clk);
            m2.tready = (c < 8) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!pending) begin
                s2.tdata = 16'($urandom); s2.tkeep = 2'($urandom); s2.tlast = 1'($urandom);
                s2.tid = 8'($urandom); s2.tdest = 8'($urandom); s2.tuser = 1'($urandom);
                s2.tvalid = (acc < 1000) && ((c < 8) || ($urandom_range(0, 1) == 1));
            end
            #1;
            if (c == 8) begin
                tests++; if (acc != 3) begin fails++; $display("FAIL simple_capacity: got %0d expected 3", acc); end
            end
            if (s2.tvalid && s2.tready) begin
                q.push_back({s2.tdata, s2.tkeep, s2.tlast, s2.tid, s2.tdest, s2.tuser});
                acc++;
            end
            pending = s2.tvalid && !s2.tready;
            if (m2.tvalid && m2.tready) begin
                act_w = {m2.tdata, m2.tkeep, m2.tlast, m2.tid, m2.tdest, m2.tuser};
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL sb_unexpected_beat%0d: got %h expected none", outn, act_w);
                end else begin
                    exp_w = q.pop_front();
                    if (act_w !== exp_w) begin fails++; $display("FAIL sb_beat%0d: got %h expected %h", outn, act_w, exp_w); end
                end
                outn++;
            end
        end
        s2.tvalid = 0; m2.tready = 0;
        tests++; if (outn != 1000) begin fails++; $display("FAIL sb_count: got %0d expected 1000", outn); end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d expected 0", q.size()); end
    endtask

    task automatic test_reset_midflight();
        int got = 0;
        m0.tready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); s0.tvalid = 1; s0.tdata = 8'(8'h11 * (c + 1));
        end
        @(negedge clk); s0.tvalid = 0; #1;
        tests++; if (m0.tvalid !== 1'b1) begin fails++; $display("FAIL midrst_pre_valid: got %b expected 1", m0.tvalid); end
        rst = 1; #1;
        tests++; if (m0.tvalid !== 1'b0) begin fails++; $display("FAIL midrst_async_clear: got %b expected 0", m0.tvalid); end
        @(negedge clk); rst = 0;
        m0.tready = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            s0.tvalid = (c == 0); s0.tdata = 8'h44;
            #1;
            if (m0.tvalid) begin
                tests++;
                if (m0.tdata !== 8'h44 || c != 2) begin
                    fails++; $display("FAIL midrst_first_out: got %h at cycle %0d expected 44 at cycle 2", m0.tdata, c);
                end
                got++;
            end
        end
        s0.tvalid = 0;
        tests++; if (got != 1) begin fails++; $display("FAIL midrst_out_count: got %0d expected 1", got); end
    endtask

    task automatic test_capacity_stats();
        int sent = 0;
        int got = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            m0.tready = (c >= 13);
            if (sent < 6) begin s0.tvalid = 1; s0.tdata = 8'(8'h61 + sent); end
            else s0.tvalid = 0;
            #1;
            if (c == 12) begin
                tests++; if (sent != 4) begin fails++; $display("FAIL skid_capacity: got %0d expected 4", sent); end
                tests++; if (s0.tready !== 1'b0) begin fails++; $display("FAIL skid_full_ready: got %b expected 0", s0.tready); end
`ifdef AXIS_PIPELINE_REG_STATS_EN
                tests++; if (occ0 !== 3'd4) begin fails++; $display("FAIL stat_occupancy: got %0d expected 4", occ0); end
                tests++; if (stall0 !== 32'd10) begin fails++; $display("FAIL stat_stall_cnt: got %0d expected 10", stall0); end
`endif
            end
            if (s0.tvalid && s0.tready) sent++;
            if (m0.tvalid && m0.tready) begin
                tests++;
                if (m0.tdata !== 8'(8'h61 + got)) begin
                    fails++; $display("FAIL drain_beat%0d: got %h expected %h", got, m0.tdata, 8'(8'h61 + got));
                end
                got++;
            end
        end
        s0.tvalid = 0;
        tests++; if (got != 6) begin fails++; $display("FAIL drain_count: got %0d expected 6", got); end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_back_to_back();
        test_skid_stall();
        test_bypass();
        test_random_scoreboard();
        test_reset_midflight();
        test_capacity_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
